// File: rtl/line_pingpong_if.sv
// Pixel write stream and read stream of the ping-pong line buffer.
// The buffer itself attaches through the slave modport.
interface line_pingpong_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  rd_ready;

    modport master (
        output wr_en, wr_data, wr_last, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  wr_en, wr_data, wr_last, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/line_pingpong.sv
// Two-bank line buffer: the producer fills one bank a line at a time while the
// consumer drains the other through a valid/ready stream with a 2-entry skid.
module line_pingpong #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clock,
    input  logic                  aclr,
    line_pingpong_if.slave        bus,
    output logic                  ovf,
    output logic [1:0]            lines_pending
);

    localparam int unsigned            Depth   = 2 ** (ADDR_WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0]  AddrOne = 1;
    localparam logic [ADDR_WIDTH:0]    LenOne  = 1;

    typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

    bank_st_e              st_q [2];
    bank_st_e              st_d [2];
    logic [ADDR_WIDTH:0]   len_q [2];
    logic [ADDR_WIDTH:0]   len_d [2];

    logic                  wr_sel_q, wr_sel_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  ovf_q, ovf_d;

    logic                  rd_sel_q, rd_sel_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_done_q, rd_done_d;

    logic                  ram_vld_q, ram_last_q;
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

    logic [DATA_WIDTH-1:0] mem [Depth];

    logic       wr_ready, wr_accept, wr_close;
    logic       pop, rd_close, space_ok, issue, issue_last;
    logic [1:0] occ;

    always_comb begin
        wr_ready  = st_q[wr_sel_q] inside {StEmpty, StFilling};
        wr_accept = bus.wr_en & wr_ready;
        wr_close  = wr_accept & (bus.wr_last | (&wr_addr_q));

        pop      = out_vld_q & bus.rd_ready;
        rd_close = pop & out_last_q;
        // Words already in flight toward the skid; never issue more than it can hold.
        occ      = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q};
        space_ok = (occ <= 2'd1) | ((occ == 2'd2) & pop);
        issue    = space_ok & ((st_q[rd_sel_q] == StFull) |
                               ((st_q[rd_sel_q] == StDraining) & ~rd_done_q));
        issue_last = (({1'b0, rd_addr_q} + LenOne) == len_q[rd_sel_q]);
    end

    // Bank states and both address pointers. Write and read sides always
    // address different banks, so their updates never collide.
    always_comb begin
        st_d      = st_q;
        len_d     = len_q;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        ovf_d     = 1'b0;
        rd_sel_d  = rd_sel_q;
        rd_addr_d = rd_addr_q;
        rd_done_d = rd_done_q;

        if (wr_accept) begin
            if (wr_close) begin
                st_d[wr_sel_q]  = StFull;
                len_d[wr_sel_q] = {1'b0, wr_addr_q} + LenOne;
                wr_sel_d        = ~wr_sel_q;
                wr_addr_d       = '0;
                ovf_d           = ~bus.wr_last;
            end else begin
                st_d[wr_sel_q] = StFilling;
                wr_addr_d      = wr_addr_q + AddrOne;
            end
        end

        if (issue) begin
            if (st_q[rd_sel_q] == StFull) st_d[rd_sel_q] = StDraining;
            if (issue_last) rd_done_d = 1'b1;
            else            rd_addr_d = rd_addr_q + AddrOne;
        end

        if (rd_close) begin
            st_d[rd_sel_q] = StEmpty;
            rd_sel_d       = ~rd_sel_q;
            rd_addr_d      = '0;
            rd_done_d      = 1'b0;
        end
    end

    // Output skid: head register drives the stream, second entry absorbs the
    // word already read out of the RAM when the consumer stalls.
    always_comb begin
        out_vld_d   = out_vld_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        skid_vld_d  = skid_vld_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;

        if (pop) begin
            if (skid_vld_q) begin
                out_vld_d   = 1'b1;
                out_last_d  = skid_last_q;
                out_data_d  = skid_data_q;
                skid_vld_d  = ram_vld_q;
                skid_last_d = ram_last_q;
                skid_data_d = ram_q;
            end else begin
                out_vld_d  = ram_vld_q;
                out_last_d = ram_last_q;
                out_data_d = ram_q;
            end
        end else if (ram_vld_q) begin
            if (!out_vld_q) begin
                out_vld_d  = 1'b1;
                out_last_d = ram_last_q;
                out_data_d = ram_q;
            end else begin
                skid_vld_d  = 1'b1;
                skid_last_d = ram_last_q;
                skid_data_d = ram_q;
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]  <= StEmpty;
                len_q[b] <= '0;
            end
            wr_sel_q    <= 1'b0;
            wr_addr_q   <= '0;
            ovf_q       <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_done_q   <= 1'b0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            st_q        <= st_d;
            len_q       <= len_d;
            wr_sel_q    <= wr_sel_d;
            wr_addr_q   <= wr_addr_d;
            ovf_q       <= ovf_d;
            rd_sel_q    <= rd_sel_d;
            rd_addr_q   <= rd_addr_d;
            rd_done_q   <= rd_done_d;
            ram_vld_q   <= issue;
            ram_last_q  <= issue & issue_last;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_last_q <= skid_last_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Simple dual-port RAM; the bank select is the address MSB.
    always_ff @(posedge clock) begin
        if (wr_accept) mem[{wr_sel_q, wr_addr_q}] <= bus.wr_data;
        if (issue)     ram_q <= mem[{rd_sel_q, rd_addr_q}];
    end

    always_comb begin
        lines_pending = 2'd0;
        for (int b = 0; b < 2; b++) begin
            if (st_q[b] inside {StFull, StDraining}) lines_pending = lines_pending + 2'd1;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = out_vld_q;
    assign bus.rd_data  = out_data_q;
    assign bus.rd_last  = out_last_q;
    assign ovf          = ovf_q;

endmodule

// File: doc/line_pingpong.md
# line_pingpong

Two-bank (ping-pong) line buffer for the bayer_to_rgb pixel path. The producer writes one complete line at a time into the free bank. The consumer then drains that line through a valid/ready stream at up to one pixel per clock, independent of the producer's pace. It is the pull-side counterpart of the free-running shift_line delay: it decouples a line-bursty source from a back-pressured sink without losing or reordering pixels.

## Interface
Parameters:
- ADDR_WIDTH, 11, each bank holds 2^ADDR_WIDTH words; this is the maximum line length.
- DATA_WIDTH, 24, pixel width.

Ports:
- clock  in  1  single clock for the whole block.
- aclr  in  1  reset, asynchronous and active-high.
- wr_en  in  1  write strobe; the word is accepted when wr_en && wr_ready.
- wr_data  in  DATA_WIDTH  write pixel.
- wr_last  in  1  marks the last pixel of a line; qualified by wr_en && wr_ready.
- wr_ready  out  1  the write bank can accept a word.
- rd_valid  out  1  rd_data holds a valid pixel.
- rd_data  out  DATA_WIDTH  read pixel, registered.
- rd_last  out  1  rd_data is the last pixel of the line.
- rd_ready  in  1  consumer accepts; transfer occurs when rd_valid && rd_ready.
- ovf  out  1  one-cycle pulse: a line was truncated at 2^ADDR_WIDTH words.
- lines_pending  out  2  number of banks in the FULL or DRAINING state (0..2).

## Operation
- Each bank has its own state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. Each bank also has a stored length register of ADDR_WIDTH+1 bits.
- Write side pointer wr_sel starts at 0.
  - wr_ready = 1 when bank[wr_sel] is EMPTY or FILLING; it is a combinational decode of registered state.
  - An accepted word is written at wr_addr, and wr_addr increments. The first accepted word moves an EMPTY bank to FILLING.
  - Accepted wr_last, or an accepted word at wr_addr = 2^ADDR_WIDTH-1:
    - stores length = wr_addr+1;
    - sets the bank to FULL;
    - toggles wr_sel and clears wr_addr to 0.
  - Hitting the address limit without wr_last pulses ovf for one cycle. The words that follow start the next line.
  - A single-word line (wr_last on the first word) is legal: length = 1.
- Read side pointer rd_sel starts at 0.
  - When bank[rd_sel] is FULL, the bank moves to DRAINING, and read addresses are issued 0..length-1.
  - The RAM has a 1-cycle registered read. A 2-entry output skid keeps full throughput under back-pressure.
  - rd_last = 1 exactly on the word at address length-1.
  - The handshake of the rd_last word sets the bank to EMPTY and toggles rd_sel.
- The RAM is inferred as simple dual-port, with 2 * 2^ADDR_WIDTH words; the bank select is the address MSB.
- The read side and write side never use the same bank at the same time, so no read-during-write case exists.
- When a write completes one bank while the read side finishes the other bank in the same cycle, both state updates apply.
- lines_pending = count of banks in FULL or DRAINING.
- Address and length arithmetic is unsigned. The length register has one extra bit so that a full 2^ADDR_WIDTH line is representable.

## Timing
- Reset values:
  - all banks EMPTY; wr_sel = rd_sel = 0; wr_addr = 0;
  - rd_valid = 0, rd_data = 0, rd_last = 0, ovf = 0, lines_pending = 0;
  - wr_ready = 1 once aclr deasserts.
- aclr asserted mid-line drops every partial and full line immediately. No output glitches: all outputs are registered or decoded from registered state.
- Latency: wr_last accepted at edge E0 -> bank FULL after E0 -> first read address issued at E1 -> rd_valid = 1 after E2.
- rd_valid, rd_data and rd_last hold stable while rd_valid && !rd_ready. rd_valid does not deassert inside a line unless a handshake has emptied the skid.
- Throughput:
  - 1 word/clock on the read side while rd_ready = 1;
  - 1 word/clock on the write side while the target bank is free.
- After the rd_last handshake at edge E, the bank is EMPTY after E. If that bank is wr_sel, wr_ready = 1 in the following cycle.
- Both banks full: wr_ready = 0 until the first bank is drained; stalled writes are not lost.

## Test plan
- Reset, write a 4-word line 0x000001..0x000004 with wr_last on the 4th word, hold rd_ready = 1 -> rd_valid rises 2 clocks after wr_last; 4 consecutive words come out with rd_last on 0x000004; lines_pending goes 1 -> 0.
- Write 3 lines of 8 words with rd_ready = 0 -> wr_ready = 0 after line 2 ends; lines_pending = 2. Release rd_ready -> 24 words come out in order, with line 3 accepted once bank 0 empties.
- Drain with rd_ready toggling pseudo-randomly -> no duplicate or dropped word; data stable while stalled.
- With ADDR_WIDTH = 3, write 10 words with no wr_last until word 10 -> ovf pulses once at word 8; line A = words 1..8 with rd_last on word 8; line B = words 9..10.
- Single-word lines back-to-back, 5 times -> five rd_valid beats, each with rd_last = 1.
- Assert aclr while a line is draining and another is FULL -> rd_valid = 0 and lines_pending = 0 immediately, wr_ready = 1 after release; a new line is transferred correctly.
